circular_shift_sched: RTL
=========================

Name: circular_shift_sched

Overview:
- Sequences the 257-entry x 32-bit circular shift datapath for the non-power-of-two NTT.
- On a start command, issues a run of shift amounts, one per issue slot: shift_k = (base + k*stride) mod SIZE for k = 0..count-1.
- Tracks in-flight shifts through the datapath's fixed register latency and raises a per-result valid/index to the consumer.
- Limits outstanding results with a credit counter that the consumer replenishes.

Parameters:
- SIZE, 257, list length and modulus for shift amounts
- SHIFT_W, 9, width of shift amount (ceil(log2(SIZE)))
- CNT_W, 9, width of count/index
- LATENCY, 2, datapath latency in cycles from shift_amount issue to shifted result
- CREDITS, 4, max results issued but not yet retired by the consumer (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- base  in  SHIFT_W  first shift amount, 0..511 accepted
- stride  in  SHIFT_W  shift increment per step, 0..511 accepted
- count  in  CNT_W  number of shifts in run
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- shift_amount  out  SHIFT_W  to datapath shift input
- issue_valid  out  1  shift_amount is a live issue this cycle
- res_valid  out  1  datapath output is a live result this cycle
- res_index  out  CNT_W  k of the result presented with res_valid
- credit_ret  in  1  consumer retires one result (one credit per cycle max)

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, issue_valid=0, res_valid=0, shift_amount=0, res_index=0; credits=CREDITS; latency pipe cleared. Reset mid-run abandons the run; no done pulse.
- Operand reduction on start: base_r = base>=SIZE ? base-SIZE : base; same for stride_r. One conditional subtract suffices since 511 < 2*SIZE. Result always in 0..SIZE-1.
- State IDLE:
  - start=1 and count=0 -> DONE (no issue).
  - start=1 and count>0 -> latch base_r, stride_r, count; acc=base_r; k=0; -> ISSUE.
- State ISSUE: each cycle with credits>0:
  - issue_valid=1, shift_amount=acc, credits decrements.
  - acc <= (acc+stride_r) reduced mod SIZE by one conditional subtract (sum < 2*SIZE).
  - k increments.
  - After issuing k=count-1 -> DRAIN.
  - With credits=0: issue_valid=0, acc/k hold.
- State DRAIN: wait until latency pipe is empty AND credits==CREDITS -> DONE.
- State DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in ISSUE and DRAIN only.
- start while busy is ignored.
- Latency pipe: LATENCY-stage shift register of {valid,k}. res_valid/res_index appear exactly LATENCY cycles after the matching issue_valid, aligned with the datapath output register.
- Credits:
  - Simultaneous issue and credit_ret in the same cycle -> count unchanged.
  - credit_ret when credits==CREDITS is ignored (saturate, no overflow).
  - credit_ret in IDLE is also ignored.
- shift_amount holds its last value when not issuing; the datapath reloads every cycle, so only issue_valid-tagged cycles are meaningful.
- Issue rate is one per cycle when credits suffice: CREDITS>=LATENCY+consumer turnaround gives full throughput.

Decomposition:
- Shared package: SIZE=257, SHIFT_W=9, WIDTH=32 constants; state enum {IDLE, ISSUE, DRAIN, DONE}; a mod-SIZE conditional-subtract function used for both operand reduction and accumulator update.
- Natural sub-module: circular_shift_sched_credit (saturating up/down credit counter with empty/full flags).
- The latency pipe stays inline.

Test Plan:
- base=5, stride=3, count=4, CREDITS=4, credit_ret pulsed 1 cycle after each res_valid:
  - issue_valid 4 consecutive cycles with shift_amount 5,8,11,14.
  - res_valid 2 cycles later with res_index 0..3.
  - done one cycle after drain.
- Wrap: base=250, stride=10, count=3 -> shift_amount 250, 3, 13.
- Unreduced operands: base=300, stride=511, count=2 -> shift_amount 43, 297 reduced to 40.
- count=0 start -> no issue_valid, busy stays 0, done pulse the cycle after start.
- CREDITS=2, count=5, consumer withholds credit_ret:
  - exactly 2 issues, then issue_valid=0 and busy=1 holding.
  - Release credit_ret -> remaining 3 issued.
  - done only after all 5 credits returned.
- Reset asserted mid-ISSUE (after 2 of 6 issues):
  - all outputs 0 immediately (async).
  - No res_valid for in-flight results, no done.
  - A new start afterwards runs cleanly from k=0.

Source files
------------

// File: rtl/circular_shift_sched_pkg.sv
// Shared constants, FSM state type, latency-pipe payload and the mod-SIZE reducer
// for the 257-point circular shift scheduler.
package circular_shift_sched_pkg;

  localparam int unsigned SIZE    = 257;
  localparam int unsigned SHIFT_W = 9;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SUM_W   = SHIFT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] k;
  } pipe_t;

  // One conditional subtract; callers guarantee x < 2*SIZE.
  function automatic logic [SHIFT_W-1:0] mod_size(input logic [SUM_W-1:0] x);
    if (x >= SUM_W'(SIZE)) begin
      return SHIFT_W'(x - SUM_W'(SIZE));
    end
    return SHIFT_W'(x);
  endfunction

endpackage

// File: rtl/circular_shift_sched_credit.sv
// Saturating up/down credit counter; starts full, registered empty/full flags.
module circular_shift_sched_credit #(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_take,
  input  logic i_ret,
  output logic o_empty,
  output logic o_full
);

  localparam int unsigned     CR_W     = $clog2(CREDITS + 1);
  localparam logic [CR_W-1:0] FULL_CNT = CR_W'(CREDITS);

  logic [CR_W-1:0] r_count;
  logic [CR_W-1:0] w_count_next;
  logic            w_inc;
  logic            w_dec;

  // A return while already full has nothing outstanding to retire.
  always_comb begin
    w_inc        = i_ret && (r_count != FULL_CNT);
    w_dec        = i_take && (r_count != '0);
    w_count_next = r_count;
    if (w_inc && !w_dec) begin
      w_count_next = r_count + CR_W'(1);
    end else if (w_dec && !w_inc) begin
      w_count_next = r_count - CR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= FULL_CNT;
      o_empty <= 1'b0;
      o_full  <= 1'b1;
    end else begin
      r_count <= w_count_next;
      o_empty <= (w_count_next == '0);
      o_full  <= (w_count_next == FULL_CNT);
    end
  end

endmodule

// File: rtl/circular_shift_sched.sv
// Issues shift_k = (base + k*stride) mod SIZE to the circular shift datapath,
// tracks results through the datapath latency and throttles with consumer credits.
module circular_shift_sched
  import circular_shift_sched_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SHIFT_W-1:0] base,
  input  logic [SHIFT_W-1:0] stride,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [SHIFT_W-1:0] shift_amount,
  output logic               issue_valid,
  output logic               res_valid,
  output logic [CNT_W-1:0]   res_index,
  input  logic               credit_ret
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_issue;
  logic               w_last;
  logic               w_ret;
  logic               w_pipe_any;
  logic               w_cr_empty;
  logic               w_cr_full;
  logic [SHIFT_W-1:0] r_acc;
  logic [SHIFT_W-1:0] r_stride;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_k;
  logic [CNT_W-1:0]   r_issue_k;
  pipe_t              r_pipe [LATENCY];

  // Consumer returns only count while a run is active.
  assign w_ret = credit_ret && (r_state != IDLE);

  circular_shift_sched_credit #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .i_take  (w_issue),
    .i_ret   (w_ret),
    .o_empty (w_cr_empty),
    .o_full  (w_cr_full)
  );

  always_comb begin
    w_pipe_any = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      w_pipe_any = w_pipe_any | r_pipe[i].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_issue      = 1'b0;
    w_last       = (r_k == (r_count - CNT_W'(1)));
    case (r_state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next = ISSUE;
            w_load       = 1'b1;
          end
        end
      end
      ISSUE: begin
        w_issue = !w_cr_empty;
        if (w_issue && w_last) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The issue register is the first in-flight stage ahead of the pipe.
        if (!issue_valid && !w_pipe_any && w_cr_full) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      issue_valid  <= 1'b0;
      shift_amount <= '0;
      r_acc        <= '0;
      r_stride     <= '0;
      r_count      <= '0;
      r_k          <= '0;
      r_issue_k    <= '0;
    end else begin
      busy        <= (w_state_next == ISSUE) || (w_state_next == DRAIN);
      done        <= (w_state_next == DONE);
      issue_valid <= w_issue;
      if (w_load) begin
        r_acc    <= mod_size({1'b0, base});
        r_stride <= mod_size({1'b0, stride});
        r_count  <= count;
        r_k      <= '0;
      end else if (w_issue) begin
        shift_amount <= r_acc;
        r_issue_k    <= r_k;
        r_acc        <= mod_size({1'b0, r_acc} + {1'b0, r_stride});
        r_k          <= r_k + CNT_W'(1);
      end
    end
  end

  // Tag pipe mirrors the datapath register stages behind the issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= '{valid: issue_valid, k: r_issue_k};
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign res_valid = r_pipe[LATENCY-1].valid;
  assign res_index = r_pipe[LATENCY-1].k;

endmodule
